// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared constants, FSM state encoding and byte-merge helper for
//             the data-memory responder slice.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Byte-enable width and the "no byte written" (read) encoding
  localparam int              BE_W     = 4;
  localparam logic [BE_W-1:0] WEN_READ = 4'b0000;

  // Word-index width: addresses select word req_addr[6:2]
  localparam int IDX_W = 5;

  // Responder FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Overlay the enabled bytes of new_word onto old_word
  function automatic logic [31:0] merge_bytes(input logic [31:0]     old_word,
                                              input logic [31:0]     new_word,
                                              input logic [BE_W-1:0] wen);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (wen[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_if
//  Brief    : Request/response handshake bundle between a requester (master)
//             and the data-memory responder (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [BE_W-1:0] req_wen;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Brief    : Word storage with byte-enabled synchronous write and two
//             asynchronous read ports. Contents are never reset.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  wire logic              clk,
  input  wire logic [BE_W-1:0]   we,
  input  wire logic [IDX_W-1:0]  waddr,
  input  wire logic [31:0]       wdata,
  input  wire logic [IDX_W-1:0]  ra_addr,
  output logic      [31:0]       ra_data,
  input  wire logic [IDX_W-1:0]  rb_addr,
  output logic      [31:0]       rb_data
);

  logic [31:0] r_mem [DEPTH];

  // Byte-lane write on the rising edge; untouched lanes keep their contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (we[b]) r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign ra_data = r_mem[ra_addr];
  assign rb_data = r_mem[rb_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Single-outstanding data-memory responder. Accepts a request in
//             IDLE, waits WAIT_CYCLES, performs a byte-enabled access with
//             read-after-write data, then holds the response until taken.
//             Build option DMEM_TEST_PORT_EN enables the display read port
//             (test_addr/test_data); otherwise test_data is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = 32
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  dmem_if.slave            bus,
  input  wire logic [4:0]  test_addr,
  output logic      [31:0] test_data
);

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [BE_W-1:0]  r_wen;
  logic [IDX_W-1:0] r_idx;
  logic             r_misal;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_access;
  logic [BE_W-1:0]  w_we;
  logic [31:0]      w_old;
  logic [31:0]      w_merged;
  logic [31:0]      w_test_rdata;
  logic             w_unused_addr_hi;

  // The access happens on the edge that leaves WAIT with an expired counter;
  // reset forces IDLE asynchronously, so a pending write can never fire.
  assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_we     = (w_access && !r_misal) ? r_wen : WEN_READ;
  assign w_merged = merge_bytes(w_old, r_wdata, r_wen);

  // Only word-index and alignment bits matter; higher bits wrap the array
  assign w_unused_addr_hi = ^bus.req_addr[31:7];

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (w_we),
    .waddr   (r_idx),
    .wdata   (r_wdata),
    .ra_addr (r_idx),
    .ra_data (w_old),
    .rb_addr (test_addr),
    .rb_data (w_test_rdata)
  );

  // Request capture, wait countdown, access and response hand-off
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_wen   <= WEN_READ;
      r_idx   <= '0;
      r_misal <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_wen   <= bus.req_wen;
            r_idx   <= bus.req_addr[6:2];
            r_misal <= (bus.req_addr[1:0] != 2'b00);
            r_wdata <= bus.req_wdata;
            r_cnt   <= C_WAIT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= r_misal ? 32'd0 : w_merged;
            r_err   <= r_misal;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

`ifdef DMEM_TEST_PORT_EN
  assign test_data = w_test_rdata;
`else
  logic w_unused_test;
  assign w_unused_test = ^w_test_rdata;
  assign test_data     = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Self-checking bench for dmem_responder (WAIT_CYCLES=2 main
//             instance plus a WAIT_CYCLES=0 instance for minimum latency).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int W = 2;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [4:0]  test_addr;
  logic [31:0] test_data;
  logic [31:0] test_data_z;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  dmem_if bus ();
  dmem_if bus_z ();

  dmem_responder #(.WAIT_CYCLES(W), .DEPTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .test_addr (test_addr),
    .test_data (test_data)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH(32)) dut_z (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus_z),
    .test_addr (test_addr),
    .test_data (test_data_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One full transaction on the main instance, started from IDLE
  task automatic do_req(input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = v.wen;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err});
    chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    // Scramble the request lines: the pending access must ignore them
    bus.req_valid = 1'b0;
    bus.req_wen   = 4'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    e = sb.pop_front();
    chk("resp_rdata", bus.resp_rdata, e.rdata);
    chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_rdata", bus.resp_rdata, e.rdata);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("release_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    vec_t vt[11];
    vec_t rd10;
    int   lat;
    exp_t e;

    vt[0]  = '{4'hF, 32'h0000_0008, 32'h1234_5678, 32'h1234_5678, 1'b0, 0};
    vt[1]  = '{4'h2, 32'h0000_0008, 32'hAABB_CCDD, 32'h1234_CC78, 1'b0, 0};
    vt[2]  = '{4'h0, 32'h0000_0008, 32'h0000_0000, 32'h1234_CC78, 1'b0, 5};
    vt[3]  = '{4'h0, 32'h0000_000A, 32'h0000_0000, 32'h0000_0000, 1'b1, 0};
    vt[4]  = '{4'hF, 32'h0000_000A, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0};
    vt[5]  = '{4'h0, 32'h0000_0008, 32'h0000_0000, 32'h1234_CC78, 1'b0, 0};
    vt[6]  = '{4'hF, 32'h0000_0010, 32'h1111_2222, 32'h1111_2222, 1'b0, 0};
    vt[7]  = '{4'h0, 32'h0000_0088, 32'h0000_0000, 32'h1234_CC78, 1'b0, 0};
    vt[8]  = '{4'hF, 32'h0000_007C, 32'h0000_0000, 32'h0000_0000, 1'b0, 0};
    vt[9]  = '{4'h9, 32'h0000_007C, 32'hA1B2_C3D4, 32'hA100_00D4, 1'b0, 0};
    vt[10] = '{4'hC, 32'hFFFF_FF90, 32'h5566_7788, 32'h5566_2222, 1'b0, 0};
    rd10   = '{4'h0, 32'h0000_0010, 32'h0000_0000, 32'h5566_2222, 1'b0, 0};

    resetn          = 1'b0;
    test_addr       = 5'd0;
    bus.req_valid   = 1'b0;
    bus.req_wen     = 4'h0;
    bus.req_addr    = 32'd0;
    bus.req_wdata   = 32'd0;
    bus.resp_ready  = 1'b0;
    bus_z.req_valid = 1'b0;
    bus_z.req_wen   = 4'h0;
    bus_z.req_addr  = 32'd0;
    bus_z.req_wdata = 32'd0;
    bus_z.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Table-driven transactions
    for (int i = 0; i < 11; i++) do_req(vt[i]);

    // Display port
    test_addr = 5'd2;
    #1;
`ifdef DMEM_TEST_PORT_EN
    chk("test_data", test_data, 32'h1234_CC78);
`else
    chk("test_data", test_data, 32'h0000_0000);
`endif

    // Reset during WAIT of a write: response cleared, write discarded
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 4'hF;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_in_wait", {31'd0, bus.req_ready}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("abort_resp_rdata", bus.resp_rdata, 32'd0);
    chk("abort_resp_err", {31'd0, bus.resp_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    do_req(rd10);

    // Zero wait states: response one cycle after acceptance
    @(negedge clk);
    bus_z.req_valid = 1'b1;
    bus_z.req_wen   = 4'hF;
    bus_z.req_addr  = 32'h0000_0004;
    bus_z.req_wdata = 32'hCAFE_F00D;
    sb.push_back('{32'hCAFE_F00D, 1'b0});
    @(posedge clk); #1;
    bus_z.req_valid = 1'b0;
    lat = 0;
    while (!bus_z.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w0_latency", 32'(lat), 32'd1);
    e = sb.pop_front();
    chk("w0_rdata", bus_z.resp_rdata, e.rdata);
    chk("w0_err", {31'd0, bus_z.resp_err}, {31'd0, e.err});
    bus_z.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_z.resp_ready = 1'b0;
    chk("w0_release", {31'd0, bus_z.resp_valid}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
